// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant and bus-sense bundle between the tristate bus arbiter and its agents.
// The arbiter takes the master modport; the agent side takes the slave modport.
interface tristate_bus_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 8
);
   localparam int OW = $clog2(NREQ);

   logic [NREQ-1:0] req;
   logic [W-1:0]    bus_in;
   logic [NREQ-1:0] gnt;
   logic [OW-1:0]   owner;
   logic            bus_idle;
   logic            keeper_err;

   modport master (
      input  req, bus_in,
      output gnt, owner, bus_idle, keeper_err
   );

   modport slave (
      output req, bus_in,
      input  gnt, owner, bus_idle, keeper_err
   );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a keeper-held tristate bus.
// Turnaround gaps sit between owners, and the bus is checked for float-back during each gap.
module tristate_bus_arbiter #(
   parameter int             NREQ      = 4,
   parameter int             W         = 8,
   parameter int             MAX_BURST = 16,
   parameter int             TURN_CYC  = 1,
   parameter logic [W-1:0]   PULL_VAL  = {W{1'b1}}
) (
   input  logic                    clk,
   input  logic                    rst_n,
   tristate_bus_arbiter_if.master  bus
);
   localparam int OW = $clog2(NREQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(TURN_CYC + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN  = 2'd1;
   localparam logic [1:0] ST_TURN = 2'd2;

   logic [1:0]      state_reg;
   logic [OW-1:0]   last_reg;
   logic [OW-1:0]   owner_reg;
   logic [NREQ-1:0] gnt_reg;
   logic            idle_reg;
   logic            err_reg;
   logic [BW-1:0]   burst_cnt_reg;
   logic [TW-1:0]   turn_cnt_reg;

   logic [OW:0]     rr_cand_next;
   logic [OW-1:0]   winner_next;
   logic            found_next;
   logic [NREQ-1:0] gnt_next;
   logic            keeper_fail;

   // Walk from last+1 with wrap; the previous owner is visited last.
   always_comb begin
      rr_cand_next = {1'b0, last_reg};
      winner_next  = '0;
      found_next   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         rr_cand_next = rr_cand_next + (OW+1)'(1);
         if (rr_cand_next == (OW+1)'(NREQ))
            rr_cand_next = '0;
         if (!found_next && bus.req[rr_cand_next[OW-1:0]]) begin
            found_next  = 1'b1;
            winner_next = rr_cand_next[OW-1:0];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
         assign gnt_next[gi] = (winner_next == OW'(gi));
      end
   endgenerate

   // Any non-PULL_VAL bit, including x/z, counts as a keeper failure.
   assign keeper_fail = (bus.bus_in !== PULL_VAL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         last_reg      <= OW'(NREQ - 1);
         owner_reg     <= '0;
         gnt_reg       <= '0;
         idle_reg      <= 1'b1;
         err_reg       <= 1'b0;
         burst_cnt_reg <= '0;
         turn_cnt_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (found_next) begin
                  state_reg     <= ST_OWN;
                  gnt_reg       <= gnt_next;
                  owner_reg     <= winner_next;
                  last_reg      <= winner_next;
                  idle_reg      <= 1'b0;
                  burst_cnt_reg <= BW'(1);
               end
            end
            ST_OWN: begin
               if (!bus.req[owner_reg] || burst_cnt_reg == BW'(MAX_BURST)) begin
                  state_reg    <= ST_TURN;
                  gnt_reg      <= '0;
                  owner_reg    <= '0;
                  idle_reg     <= 1'b1;
                  turn_cnt_reg <= TW'(1);
               end else if (burst_cnt_reg != BW'(MAX_BURST)) begin
                  burst_cnt_reg <= burst_cnt_reg + BW'(1);
               end
            end
            ST_TURN: begin
               if (turn_cnt_reg == TW'(TURN_CYC)) begin
                  if (keeper_fail)
                     err_reg <= 1'b1;
                  if (found_next) begin
                     state_reg     <= ST_OWN;
                     gnt_reg       <= gnt_next;
                     owner_reg     <= winner_next;
                     last_reg      <= winner_next;
                     idle_reg      <= 1'b0;
                     burst_cnt_reg <= BW'(1);
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end else begin
                  turn_cnt_reg <= turn_cnt_reg + TW'(1);
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               gnt_reg   <= '0;
               owner_reg <= '0;
               idle_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.gnt        = gnt_reg;
   assign bus.owner      = owner_reg;
   assign bus.bus_idle   = idle_reg;
   assign bus.keeper_err = err_reg;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios plus random requests.
// Every cycle is checked against an abstract owner/tenure/turnaround model.
module tb_tristate_bus_arbiter;
   localparam int NREQ = 4;
   localparam int W = 8;
   localparam int MAX_BURST = 16;
   localparam int TURN_CYC = 1;
   localparam logic [W-1:0] PULL = 8'hFF;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   tristate_bus_arbiter_if #(.NREQ(NREQ), .W(W)) bus_if ();

   tristate_bus_arbiter #(
      .NREQ(NREQ), .W(W), .MAX_BURST(MAX_BURST), .TURN_CYC(TURN_CYC), .PULL_VAL(PULL)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus_if)
   );

   logic [NREQ-1:0] req_drv = '0;
   bit              kf_en = 1'b0;
   logic [W-1:0]    kf_val = '0;
   logic [W-1:0]    drive_val [NREQ] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
   logic [W-1:0]    bus_net;

   // Shared net: keeper value unless a granted agent drives; overlap shows as x.
   always_comb begin
      bus_net = PULL;
      for (int i = 0; i < NREQ; i++)
         if (bus_if.gnt[i] === 1'b1) bus_net = drive_val[i];
      if ($countones(bus_if.gnt) > 1) bus_net = 'x;
      if (kf_en) bus_net = kf_val;
   end

   assign bus_if.req    = req_drv;
   assign bus_if.bus_in = bus_net;

   int total = 0;
   int bad = 0;

   // Reference model: owner index (-1 = none), cycles owned, turnaround cycles remaining.
   int m_owner, m_tenure, m_turn, m_last;
   bit m_err;
   int run;
   int ten_q[$];
   int own_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_pick(input logic [NREQ-1:0] r);
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (m_last + k) % NREQ;
         if (r[c]) begin
            m_owner = c;
            m_last = c;
            m_tenure = 1;
            return;
         end
      end
   endfunction

   function automatic void m_edge(input logic [NREQ-1:0] r, input logic [W-1:0] bv);
      if (m_owner >= 0) begin
         if (!r[m_owner] || m_tenure == MAX_BURST) begin
            m_owner = -1;
            m_turn = TURN_CYC;
         end else begin
            m_tenure++;
         end
      end else if (m_turn > 0) begin
         m_turn--;
         if (m_turn == 0) begin
            if (bv !== PULL) m_err = 1'b1;
            m_pick(r);
         end
      end else begin
         m_pick(r);
      end
   endfunction

   task automatic check_outputs();
      logic [NREQ-1:0] eg;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("gnt", 32'(bus_if.gnt), 32'(eg));
      chk("owner", 32'(bus_if.owner), (m_owner >= 0) ? m_owner : 0);
      chk("bus_idle", 32'(bus_if.bus_idle), 32'(m_owner < 0));
      chk("keeper_err", 32'(bus_if.keeper_err), 32'(m_err));
      chk("onehot", 32'($countones(bus_if.gnt) <= 1), 32'd1);
      $display("t=%0t req=%b gnt=%b owner=%0d idle=%b kerr=%b bus=%h", $time, req_drv,
               bus_if.gnt, bus_if.owner, bus_if.bus_idle, bus_if.keeper_err, bus_net);
      if (bus_if.gnt !== '0) begin
         if (run == 0) own_q.push_back(int'(bus_if.owner));
         run++;
      end else if (run > 0) begin
         ten_q.push_back(run);
         run = 0;
      end
   endtask

   // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
   task automatic step(input logic [NREQ-1:0] r, input bit kf, input logic [W-1:0] kv);
      logic [W-1:0] bv;
      req_drv = r;
      kf_en = kf;
      kf_val = kv;
      bv = kf ? kv : ((m_owner >= 0) ? drive_val[m_owner] : PULL);
      @(posedge clk);
      m_edge(r, bv);
      @(negedge clk);
      kf_en = 1'b0;
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_owner = -1;
      m_turn = 0;
      m_last = NREQ - 1;
      m_err = 1'b0;
      run = 0;
      #1;
      chk("rst_gnt", 32'(bus_if.gnt), 32'd0);
      chk("rst_owner", 32'(bus_if.owner), 32'd0);
      chk("rst_idle", 32'(bus_if.bus_idle), 32'd1);
      chk("rst_kerr", 32'(bus_if.keeper_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   initial begin
      #2;
      @(negedge clk);
      do_reset();

      // Reset and float
      for (int i = 0; i < 5; i++) begin
         step('0, 1'b0, '0);
         chk("float", 32'(bus_net), 32'(PULL));
      end

      // Single owner
      ten_q.delete(); own_q.delete();
      for (int i = 0; i < 3; i++) begin
         step(4'b0010, 1'b0, '0);
         chk("bus_a5", 32'(bus_net), 32'hA5);
      end
      step('0, 1'b0, '0);
      step('0, 1'b0, '0);
      chk("single_len", q_at(ten_q, 0), 3);
      chk("single_own", q_at(own_q, 0), 1);

      // Keeper fault during the turnaround cycle, then sticky through further grants
      step(4'b0010, 1'b0, '0);
      step(4'b0010, 1'b0, '0);
      step('0, 1'b0, '0);
      step('0, 1'b1, 8'h7F);
      chk("kerr_set", 32'(bus_if.keeper_err), 32'd1);
      for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, '0);
      step('0, 1'b0, '0);
      step('0, 1'b0, '0);
      chk("kerr_sticky", 32'(bus_if.keeper_err), 32'd1);
      @(negedge clk);
      do_reset();

      // Contention round-robin
      ten_q.delete(); own_q.delete();
      for (int i = 0; i < 100; i++) step(4'b1111, 1'b0, '0);
      step('0, 1'b0, '0);
      step('0, 1'b0, '0);
      chk("rr_own0", q_at(own_q, 0), 0);
      chk("rr_own1", q_at(own_q, 1), 1);
      chk("rr_own2", q_at(own_q, 2), 2);
      chk("rr_own3", q_at(own_q, 3), 3);
      chk("rr_own4", q_at(own_q, 4), 0);
      for (int i = 0; i < 4; i++) chk("rr_len", q_at(ten_q, i), MAX_BURST);

      // Sole requester: req held for 42 edges gives tenures 16, 16, 8
      ten_q.delete(); own_q.delete();
      for (int i = 0; i < 42; i++) step(4'b0100, 1'b0, '0);
      step('0, 1'b0, '0);
      step('0, 1'b0, '0);
      chk("sole_n", ten_q.size(), 3);
      chk("sole_len0", q_at(ten_q, 0), 16);
      chk("sole_len1", q_at(ten_q, 1), 16);
      chk("sole_len2", q_at(ten_q, 2), 8);
      for (int i = 0; i < 3; i++) chk("sole_own", q_at(own_q, i), 2);

      // Asynchronous reset mid-burst, then requester 0 wins first
      for (int i = 0; i < 5; i++) step(4'b1000, 1'b0, '0);
      chk("pre_rst_gnt", 32'(bus_if.gnt), 32'b1000);
      #2;
      do_reset();
      step(4'b1001, 1'b0, '0);
      chk("post_rst_gnt", 32'(bus_if.gnt), 32'b0001);

      // Random traffic
      step('0, 1'b0, '0);
      for (int i = 0; i < 1500; i++) begin
         logic [NREQ-1:0] r;
         r = req_drv;
         if ($urandom_range(0, 7) == 0) r = NREQ'($urandom_range(0, 15));
         step(r, ($urandom_range(0, 59) == 0), W'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
